// File: rtl/dds_tv_pkg.sv
// Shared types for the DDS test-vector sequencer.
// Holds the run FSM encoding, default field widths and table address sizing.
package dds_tv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tv_state_e;

   localparam int DEF_FREQ_BITS   = 10;
   localparam int DEF_PH_BITS     = 10;
   localparam int DEF_SAMPLE_BITS = 10;
   localparam int DEF_RUN_LEN     = 510;
   localparam int DEF_NUM_EVENTS  = 4;
   localparam int DEF_NUM_CH      = 1;

   function automatic int addr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dds_tv_if.sv
// Bench-controller <-> sequencer bus: run control, table writes, vector outputs.
// master = controller side, slave = sequencer side.
interface dds_tv_if
   import dds_tv_pkg::*;
#(
   parameter int FREQ_OFFSET_BITS = DEF_FREQ_BITS,
   parameter int PH_OFFSET_BITS   = DEF_PH_BITS,
   parameter int SAMPLE_BITS      = DEF_SAMPLE_BITS,
   parameter int NUM_EVENTS       = DEF_NUM_EVENTS,
   parameter int NUM_CH           = DEF_NUM_CH
);
   localparam int AW = addr_bits(NUM_EVENTS);

   logic                               start;
   logic                               stall;
   logic                               tbl_we;
   logic [AW-1:0]                      tbl_addr;
   logic                               tbl_valid;
   logic [SAMPLE_BITS-1:0]             tbl_sample;
   logic [NUM_CH-1:0]                  tbl_ch;
   logic [FREQ_OFFSET_BITS-1:0]        tbl_freq;
   logic                               tbl_freq_we;
   logic [PH_OFFSET_BITS-1:0]          tbl_ph;
   logic                               tbl_ph_we;
   logic [FREQ_OFFSET_BITS-1:0]        tbl_step;
   logic [SAMPLE_BITS-1:0]             sample_num;
   logic                               vect_valid;
   logic [NUM_CH*FREQ_OFFSET_BITS-1:0] freq_offset;
   logic [NUM_CH-1:0]                  freq_offset_we;
   logic [NUM_CH*PH_OFFSET_BITS-1:0]   ph_offset;
   logic [NUM_CH-1:0]                  ph_offset_we;
   logic                               busy;
   logic                               done;

   modport master (
      output start, stall, tbl_we, tbl_addr, tbl_valid, tbl_sample,
      output tbl_ch, tbl_freq, tbl_freq_we, tbl_ph, tbl_ph_we, tbl_step,
      input  sample_num, vect_valid, freq_offset, freq_offset_we,
      input  ph_offset, ph_offset_we, busy, done
   );

   modport slave (
      input  start, stall, tbl_we, tbl_addr, tbl_valid, tbl_sample,
      input  tbl_ch, tbl_freq, tbl_freq_we, tbl_ph, tbl_ph_we, tbl_step,
      output sample_num, vect_valid, freq_offset, freq_offset_we,
      output ph_offset, ph_offset_we, busy, done
   );

endinterface

// File: rtl/dds_tv_event_match.sv
// Event table storage plus parallel compare against the sample counter.
// Per channel the lowest-index matching entry wins. Sweep step stored with FREQ_SWEEP_EN.
module dds_tv_event_match
   import dds_tv_pkg::*;
#(
   parameter int FREQ_OFFSET_BITS = DEF_FREQ_BITS,
   parameter int PH_OFFSET_BITS   = DEF_PH_BITS,
   parameter int SAMPLE_BITS      = DEF_SAMPLE_BITS,
   parameter int NUM_EVENTS       = DEF_NUM_EVENTS,
   parameter int NUM_CH           = DEF_NUM_CH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               tbl_we,
   input  logic [addr_bits(NUM_EVENTS)-1:0]   tbl_addr,
   input  logic                               tbl_valid,
   input  logic [SAMPLE_BITS-1:0]             tbl_sample,
   input  logic [NUM_CH-1:0]                  tbl_ch,
   input  logic [FREQ_OFFSET_BITS-1:0]        tbl_freq,
   input  logic                               tbl_freq_we,
   input  logic [PH_OFFSET_BITS-1:0]          tbl_ph,
   input  logic                               tbl_ph_we,
`ifdef FREQ_SWEEP_EN
   input  logic [FREQ_OFFSET_BITS-1:0]        tbl_step,
   output logic [NUM_CH*FREQ_OFFSET_BITS-1:0] win_step,
`endif
   input  logic [SAMPLE_BITS-1:0]             cnt,
   output logic [NUM_CH-1:0]                  hit_freq,
   output logic [NUM_CH-1:0]                  hit_ph,
   output logic [NUM_CH*FREQ_OFFSET_BITS-1:0] win_freq,
   output logic [NUM_CH*PH_OFFSET_BITS-1:0]   win_ph
);
   localparam int FB = FREQ_OFFSET_BITS;
   localparam int PB = PH_OFFSET_BITS;
   localparam int SB = SAMPLE_BITS;

   logic          ent_v   [NUM_EVENTS];
   logic [SB-1:0] ent_s   [NUM_EVENTS];
   logic [NUM_CH-1:0] ent_ch [NUM_EVENTS];
   logic [FB-1:0] ent_f   [NUM_EVENTS];
   logic          ent_fwe [NUM_EVENTS];
   logic [PB-1:0] ent_p   [NUM_EVENTS];
   logic          ent_pwe [NUM_EVENTS];
`ifdef FREQ_SWEEP_EN
   logic [FB-1:0] ent_st  [NUM_EVENTS];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < NUM_EVENTS; e++) begin
            ent_v[e]   <= 1'b0;
            ent_s[e]   <= '0;
            ent_ch[e]  <= '0;
            ent_f[e]   <= '0;
            ent_fwe[e] <= 1'b0;
            ent_p[e]   <= '0;
            ent_pwe[e] <= 1'b0;
`ifdef FREQ_SWEEP_EN
            ent_st[e]  <= '0;
`endif
         end
      end else if (tbl_we && int'(tbl_addr) < NUM_EVENTS) begin
         ent_v[tbl_addr]   <= tbl_valid;
         ent_s[tbl_addr]   <= tbl_sample;
         ent_ch[tbl_addr]  <= tbl_ch;
         ent_f[tbl_addr]   <= tbl_freq;
         ent_fwe[tbl_addr] <= tbl_freq_we;
         ent_p[tbl_addr]   <= tbl_ph;
         ent_pwe[tbl_addr] <= tbl_ph_we;
`ifdef FREQ_SWEEP_EN
         ent_st[tbl_addr]  <= tbl_step;
`endif
      end
   end

   // Scan high to low so the lowest matching index overwrites last.
   always_comb begin
      hit_freq = '0;
      hit_ph   = '0;
      win_freq = '0;
      win_ph   = '0;
`ifdef FREQ_SWEEP_EN
      win_step = '0;
`endif
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int e = NUM_EVENTS - 1; e >= 0; e--) begin
            if (ent_v[e] && ent_s[e] == cnt && ent_ch[e][ch]) begin
               hit_freq[ch]          = ent_fwe[e];
               hit_ph[ch]            = ent_pwe[e];
               win_freq[ch*FB +: FB] = ent_f[e];
               win_ph[ch*PB +: PB]   = ent_p[e];
`ifdef FREQ_SWEEP_EN
               win_step[ch*FB +: FB] = ent_st[e];
`endif
            end
         end
      end
   end

endmodule

// File: rtl/dds_bhv_test_vect_seq.sv
// Table-driven DDS test-vector sequencer: run FSM, sample counter, registered outputs.
// Optional FREQ_SWEEP_EN adds a per-channel frequency step applied between events.
module dds_bhv_test_vect_seq
   import dds_tv_pkg::*;
#(
   parameter int FREQ_OFFSET_BITS = DEF_FREQ_BITS,
   parameter int PH_OFFSET_BITS   = DEF_PH_BITS,
   parameter int SAMPLE_BITS      = DEF_SAMPLE_BITS,
   parameter int RUN_LEN          = DEF_RUN_LEN,
   parameter int NUM_EVENTS       = DEF_NUM_EVENTS,
   parameter int NUM_CH           = DEF_NUM_CH
) (
   input logic     clk,
   input logic     rst,
   dds_tv_if.slave bus
);
   localparam int FB = FREQ_OFFSET_BITS;
   localparam int PB = PH_OFFSET_BITS;
   localparam int SB = SAMPLE_BITS;
   localparam logic [SB-1:0] LAST = SB'(RUN_LEN - 1);

   tv_state_e              state_q, state_d;
   logic [SB-1:0]          cnt_q, cnt_d;
   logic [SB-1:0]          num_q, num_d;
   logic                   valid_q, valid_d;
   logic [NUM_CH*FB-1:0]   fo_q, fo_d;
   logic [NUM_CH-1:0]      fwe_q, fwe_d;
   logic [NUM_CH*PB-1:0]   po_q, po_d;
   logic [NUM_CH-1:0]      pwe_q, pwe_d;
   logic [NUM_CH-1:0]      hit_freq, hit_ph;
   logic [NUM_CH*FB-1:0]   win_freq;
   logic [NUM_CH*PB-1:0]   win_ph;
`ifdef FREQ_SWEEP_EN
   logic [NUM_CH*FB-1:0]   win_step;
   logic [NUM_CH*FB-1:0]   step_q, step_d;
`else
   logic                   unused_step;
   assign unused_step = ^bus.tbl_step;
`endif

   dds_tv_event_match #(
      .FREQ_OFFSET_BITS (FB),
      .PH_OFFSET_BITS   (PB),
      .SAMPLE_BITS      (SB),
      .NUM_EVENTS       (NUM_EVENTS),
      .NUM_CH           (NUM_CH)
   ) u_match (
      .clk         (clk),
      .rst         (rst),
      .tbl_we      (bus.tbl_we),
      .tbl_addr    (bus.tbl_addr),
      .tbl_valid   (bus.tbl_valid),
      .tbl_sample  (bus.tbl_sample),
      .tbl_ch      (bus.tbl_ch),
      .tbl_freq    (bus.tbl_freq),
      .tbl_freq_we (bus.tbl_freq_we),
      .tbl_ph      (bus.tbl_ph),
      .tbl_ph_we   (bus.tbl_ph_we),
`ifdef FREQ_SWEEP_EN
      .tbl_step    (bus.tbl_step),
      .win_step    (win_step),
`endif
      .cnt         (cnt_q),
      .hit_freq    (hit_freq),
      .hit_ph      (hit_ph),
      .win_freq    (win_freq),
      .win_ph      (win_ph)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         num_q   <= '0;
         valid_q <= 1'b0;
         fo_q    <= '0;
         fwe_q   <= '0;
         po_q    <= '0;
         pwe_q   <= '0;
`ifdef FREQ_SWEEP_EN
         step_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         valid_q <= valid_d;
         fo_q    <= fo_d;
         fwe_q   <= fwe_d;
         po_q    <= po_d;
         pwe_q   <= pwe_d;
`ifdef FREQ_SWEEP_EN
         step_q  <= step_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      valid_d = valid_q;
      fo_d    = fo_q;
      fwe_d   = fwe_q;
      po_d    = po_q;
      pwe_d   = pwe_q;
`ifdef FREQ_SWEEP_EN
      step_d  = step_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               cnt_d   = '0;
`ifdef FREQ_SWEEP_EN
               step_d  = '0;
`endif
            end
         end
         RUN: begin
            // Stall freezes everything; the held vector is consumed on release.
            if (!bus.stall) begin
               if (valid_q && num_q == LAST) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  fwe_d   = '0;
                  pwe_d   = '0;
               end else begin
                  num_d   = cnt_q;
                  valid_d = 1'b1;
                  if (cnt_q != LAST)
                     cnt_d = cnt_q + SB'(1);
                  for (int ch = 0; ch < NUM_CH; ch++) begin
                     fwe_d[ch] = 1'b0;
                     pwe_d[ch] = 1'b0;
                     if (hit_ph[ch]) begin
                        po_d[ch*PB +: PB] = win_ph[ch*PB +: PB];
                        pwe_d[ch]         = 1'b1;
                     end
                     if (hit_freq[ch]) begin
                        fo_d[ch*FB +: FB] = win_freq[ch*FB +: FB];
                        fwe_d[ch]         = 1'b1;
`ifdef FREQ_SWEEP_EN
                        step_d[ch*FB +: FB] = win_step[ch*FB +: FB];
                     end else if (step_q[ch*FB +: FB] != '0) begin
                        fo_d[ch*FB +: FB] = fo_q[ch*FB +: FB]
                                          + step_q[ch*FB +: FB];
                        fwe_d[ch]         = 1'b1;
`endif
                     end
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.sample_num     = num_q;
   assign bus.vect_valid     = valid_q;
   assign bus.freq_offset    = fo_q;
   assign bus.freq_offset_we = fwe_q;
   assign bus.ph_offset      = po_q;
   assign bus.ph_offset_we   = pwe_q;
   assign bus.busy           = (state_q == RUN);
   assign bus.done           = (state_q == DONE);

endmodule

// File: tb/tb_dds_bhv_test_vect_seq.sv
// Directed bench for dds_bhv_test_vect_seq: three instances cover
// the 1-channel/510-sample run, a 2-channel table and a 1-sample run.
module tb_dds_bhv_test_vect_seq;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   dds_tv_if #(.NUM_EVENTS(4), .NUM_CH(1)) b1 ();
   dds_tv_if #(.NUM_EVENTS(4), .NUM_CH(2)) b2 ();
   dds_tv_if #(.NUM_EVENTS(1), .NUM_CH(1)) b3 ();

   dds_bhv_test_vect_seq #(.RUN_LEN(510), .NUM_EVENTS(4), .NUM_CH(1))
      u1 (.clk(clk), .rst(rst), .bus(b1));
   dds_bhv_test_vect_seq #(.RUN_LEN(8), .NUM_EVENTS(4), .NUM_CH(2))
      u2 (.clk(clk), .rst(rst), .bus(b2));
   dds_bhv_test_vect_seq #(.RUN_LEN(1), .NUM_EVENTS(1), .NUM_CH(1))
      u3 (.clk(clk), .rst(rst), .bus(b3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_init;
      b1.start = 0; b1.stall = 0; b1.tbl_we = 0; b1.tbl_addr = 0;
      b1.tbl_valid = 0; b1.tbl_sample = 0; b1.tbl_ch = 0; b1.tbl_freq = 0;
      b1.tbl_freq_we = 0; b1.tbl_ph = 0; b1.tbl_ph_we = 0; b1.tbl_step = 0;
      b2.start = 0; b2.stall = 0; b2.tbl_we = 0; b2.tbl_addr = 0;
      b2.tbl_valid = 0; b2.tbl_sample = 0; b2.tbl_ch = 0; b2.tbl_freq = 0;
      b2.tbl_freq_we = 0; b2.tbl_ph = 0; b2.tbl_ph_we = 0; b2.tbl_step = 0;
      b3.start = 0; b3.stall = 0; b3.tbl_we = 0; b3.tbl_addr = 0;
      b3.tbl_valid = 0; b3.tbl_sample = 0; b3.tbl_ch = 0; b3.tbl_freq = 0;
      b3.tbl_freq_we = 0; b3.tbl_ph = 0; b3.tbl_ph_we = 0; b3.tbl_step = 0;
   endtask

   task automatic wr1(input int a, input bit v, input int s, input int f,
                      input bit fwe, input int p, input bit pwe, input int st);
      b1.tbl_we = 1; b1.tbl_addr = 2'(a); b1.tbl_valid = v;
      b1.tbl_sample = 10'(s); b1.tbl_ch = 1'b1; b1.tbl_freq = 10'(f);
      b1.tbl_freq_we = fwe; b1.tbl_ph = 10'(p); b1.tbl_ph_we = pwe;
      b1.tbl_step = 10'(st);
      tick;
      b1.tbl_we = 0;
   endtask

   task automatic wr2(input int a, input bit v, input int s, input int m,
                      input int f, input bit fwe, input int p, input bit pwe,
                      input int st);
      b2.tbl_we = 1; b2.tbl_addr = 2'(a); b2.tbl_valid = v;
      b2.tbl_sample = 10'(s); b2.tbl_ch = 2'(m); b2.tbl_freq = 10'(f);
      b2.tbl_freq_we = fwe; b2.tbl_ph = 10'(p); b2.tbl_ph_we = pwe;
      b2.tbl_step = 10'(st);
      tick;
      b2.tbl_we = 0;
   endtask

   task automatic start1;
      b1.start = 1;
      tick;
      b1.start = 0;
   endtask

   task automatic test_reset;
      logic [4:0] flags;
      int bad;
      rst = 1;
      tick;
      tick;
      flags = {b1.vect_valid, b1.busy, b1.done, b1.freq_offset_we,
               b1.ph_offset_we};
      n_assert++;
      if (flags !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000", flags);
      end
      n_assert++;
      if ({b1.sample_num, b1.freq_offset, b1.ph_offset} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0",
                  {b1.sample_num, b1.freq_offset, b1.ph_offset});
      end
      n_assert++;
      if ({b2.vect_valid, b2.busy, b2.done, b2.freq_offset} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_u2: got %h want 0",
                  {b2.vect_valid, b2.busy, b2.done, b2.freq_offset});
      end
      rst = 0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (b1.vect_valid || b1.busy || b1.done || b1.freq_offset_we
             || b1.ph_offset_we)
            bad++;
      end
      n_assert++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
      end
   endtask

   task automatic test_basic;
      logic [12:0] got, exp;
      wr1(0, 1, 0, 0, 1, 0, 1, 0);
      wr1(1, 1, 1, 0, 1, 0, 1, 0);
      start1;
      n_assert++;
      if ({b1.busy, b1.vect_valid, b1.done} !== 3'b100) begin
         n_fail++;
         $display("FAIL basic_start: got %b want 100",
                  {b1.busy, b1.vect_valid, b1.done});
      end
      for (int k = 0; k < 510; k++) begin
         tick;
         got = {b1.vect_valid, b1.sample_num, b1.freq_offset_we,
                b1.ph_offset_we};
         exp = {1'b1, 10'(k), k < 2, k < 2};
         n_assert++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL basic_k%0d: got %h want %h", k, got, exp);
         end
      end
      tick;
      n_assert++;
      if ({b1.done, b1.busy, b1.vect_valid, b1.freq_offset_we,
           b1.ph_offset_we} !== 5'b10000) begin
         n_fail++;
         $display("FAIL basic_done: got %b want 10000",
                  {b1.done, b1.busy, b1.vect_valid, b1.freq_offset_we,
                   b1.ph_offset_we});
      end
      tick;
      tick;
      n_assert++;
      if ({b1.done, b1.vect_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL basic_hold_done: got %b want 10",
                  {b1.done, b1.vect_valid});
      end
   endtask

   task automatic test_stall;
      logic [12:0] got;
      start1;
      tick;
      tick;
      b1.stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick;
         got = {b1.vect_valid, b1.sample_num, b1.freq_offset_we,
                b1.ph_offset_we};
         n_assert++;
         if (got !== {1'b1, 10'd1, 2'b11}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got %h want %h", i, got,
                     {1'b1, 10'd1, 2'b11});
         end
      end
      b1.stall = 0;
      tick;
      got = {b1.vect_valid, b1.sample_num, b1.freq_offset_we, b1.ph_offset_we};
      n_assert++;
      if (got !== {1'b1, 10'd2, 2'b00}) begin
         n_fail++;
         $display("FAIL stall_next: got %h want %h", got, {1'b1, 10'd2, 2'b00});
      end
      for (int i = 0; i < 600 && !(b1.vect_valid && b1.sample_num == 10'd509);
           i++)
         tick;
      n_assert++;
      if ({b1.vect_valid, b1.sample_num} !== {1'b1, 10'd509}) begin
         n_fail++;
         $display("FAIL stall_reach_last: got %h want %h",
                  {b1.vect_valid, b1.sample_num}, {1'b1, 10'd509});
      end
      b1.stall = 1;
      tick;
      n_assert++;
      if ({b1.vect_valid, b1.sample_num, b1.done} !== {1'b1, 10'd509, 1'b0})
      begin
         n_fail++;
         $display("FAIL stall_last: got %h want %h",
                  {b1.vect_valid, b1.sample_num, b1.done},
                  {1'b1, 10'd509, 1'b0});
      end
      b1.stall = 0;
      tick;
      n_assert++;
      if ({b1.done, b1.vect_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_done: got %b want 10", {b1.done, b1.vect_valid});
      end
   endtask

   task automatic test_values;
      logic [32:0] got, exp;
      wr1(0, 1, 2, 300, 1, 0, 0, 0);
      wr1(1, 1, 2, 999, 1, 77, 1, 0);
      wr1(2, 1, 4, 0, 0, 55, 1, 0);
      wr1(3, 1, 600, 5, 1, 5, 1, 0);
      start1;
      for (int k = 0; k < 510; k++) begin
         tick;
         got = {b1.vect_valid, b1.sample_num, b1.freq_offset_we,
                b1.ph_offset_we, b1.freq_offset, b1.ph_offset};
         exp = {1'b1, 10'(k), k == 2, k == 4,
                (k >= 2) ? 10'd300 : 10'd0, (k >= 4) ? 10'd55 : 10'd0};
         n_assert++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL values_k%0d: got %h want %h", k, got, exp);
         end
      end
      tick;
      n_assert++;
      if ({b1.done, b1.freq_offset, b1.ph_offset} !== {1'b1, 10'd300, 10'd55})
      begin
         n_fail++;
         $display("FAIL values_retain: got %h want %h",
                  {b1.done, b1.freq_offset, b1.ph_offset},
                  {1'b1, 10'd300, 10'd55});
      end
   endtask

   task automatic test_rst_mid;
      int bad;
      start1;
      for (int i = 0; i < 200 && !(b1.vect_valid && b1.sample_num == 10'd100);
           i++)
         tick;
      n_assert++;
      if ({b1.vect_valid, b1.sample_num} !== {1'b1, 10'd100}) begin
         n_fail++;
         $display("FAIL rst_reach100: got %h want %h",
                  {b1.vect_valid, b1.sample_num}, {1'b1, 10'd100});
      end
      rst = 1;
      #1;
      n_assert++;
      if ({b1.vect_valid, b1.busy, b1.done, b1.sample_num, b1.freq_offset,
           b1.ph_offset} !== 33'd0) begin
         n_fail++;
         $display("FAIL rst_async: got %h want 0",
                  {b1.vect_valid, b1.busy, b1.done, b1.sample_num,
                   b1.freq_offset, b1.ph_offset});
      end
      tick;
      rst = 0;
      start1;
      bad = 0;
      for (int k = 0; k < 510; k++) begin
         tick;
         if (!b1.vect_valid || b1.freq_offset_we || b1.ph_offset_we)
            bad++;
      end
      tick;
      n_assert++;
      if ({b1.done, 32'(bad)} !== {1'b1, 32'd0}) begin
         n_fail++;
         $display("FAIL rst_replay: got done=%b bad=%0d want done=1 bad=0",
                  b1.done, bad);
      end
   endtask

   task automatic test_priority;
      logic [54:0] got, exp;
      logic [9:0]  ef0, ef1, ep0;
      logic [1:0]  efwe, epwe;
      wr2(0, 1, 5, 1, 111, 1, 222, 1, 0);
      wr2(2, 1, 5, 1, 333, 1, 444, 1, 0);
      wr2(3, 1, 6, 3, 500, 1, 0, 0, 0);
      b2.start = 1;
      tick;
      b2.start = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
         efwe = (k == 4) ? 2'b10 : (k == 5) ? 2'b01 : (k == 6) ? 2'b11 : 2'b00;
         epwe = (k == 5) ? 2'b01 : 2'b00;
         ef0  = (k >= 6) ? 10'd500 : (k >= 5) ? 10'd111 : 10'd0;
         ef1  = (k >= 6) ? 10'd500 : (k >= 4) ? 10'd66 : 10'd0;
         ep0  = (k >= 5) ? 10'd222 : 10'd0;
         got = {b2.vect_valid, b2.sample_num, b2.freq_offset_we,
                b2.ph_offset_we, b2.freq_offset, b2.ph_offset};
         exp = {1'b1, 10'(k), efwe, epwe, ef1, ef0, 10'd0, ep0};
         n_assert++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL prio_k%0d: got %h want %h", k, got, exp);
         end
         if (k == 2) begin
            b2.tbl_we = 1; b2.tbl_addr = 2'd1; b2.tbl_valid = 1;
            b2.tbl_sample = 10'd4; b2.tbl_ch = 2'b10; b2.tbl_freq = 10'd66;
            b2.tbl_freq_we = 1; b2.tbl_ph = 0; b2.tbl_ph_we = 0;
            b2.tbl_step = 0;
         end
         if (k == 3) begin
            b2.tbl_we = 0;
            b2.start  = 1;
         end
         if (k == 4)
            b2.start = 0;
      end
      tick;
      n_assert++;
      if ({b2.done, b2.vect_valid, b2.freq_offset_we} !== 4'b1000) begin
         n_fail++;
         $display("FAIL prio_done: got %b want 1000",
                  {b2.done, b2.vect_valid, b2.freq_offset_we});
      end
   endtask

   task automatic test_run_len_one;
      logic [32:0] got;
      b3.tbl_we = 1; b3.tbl_addr = 1'b0; b3.tbl_valid = 1; b3.tbl_sample = 0;
      b3.tbl_ch = 1'b1; b3.tbl_freq = 10'd9; b3.tbl_freq_we = 1;
      b3.tbl_ph = 10'd3; b3.tbl_ph_we = 1;
      tick;
      b3.tbl_we = 0;
      b3.start  = 1;
      tick;
      b3.start  = 0;
      tick;
      got = {b3.vect_valid, b3.sample_num, b3.freq_offset_we, b3.ph_offset_we,
             b3.freq_offset, b3.ph_offset};
      n_assert++;
      if (got !== {1'b1, 10'd0, 2'b11, 10'd9, 10'd3}) begin
         n_fail++;
         $display("FAIL len1_vec: got %h want %h", got,
                  {1'b1, 10'd0, 2'b11, 10'd9, 10'd3});
      end
      tick;
      n_assert++;
      if ({b3.done, b3.busy, b3.vect_valid, b3.freq_offset_we,
           b3.freq_offset} !== {4'b1000, 10'd9}) begin
         n_fail++;
         $display("FAIL len1_done: got %h want %h",
                  {b3.done, b3.busy, b3.vect_valid, b3.freq_offset_we,
                   b3.freq_offset}, {4'b1000, 10'd9});
      end
   endtask

   task automatic test_sweep;
      logic [32:0] got, exp;
      logic [9:0]  ef0;
      logic [1:0]  efwe;
      wr2(0, 0, 0, 0, 0, 0, 0, 0, 0);
      wr2(1, 0, 0, 0, 0, 0, 0, 0, 0);
      wr2(2, 0, 0, 0, 0, 0, 0, 0, 0);
      wr2(3, 1, 3, 1, 1020, 1, 0, 0, 3);
      b2.start = 1;
      tick;
      b2.start = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
`ifdef FREQ_SWEEP_EN
         efwe = (k >= 3) ? 2'b01 : 2'b00;
         ef0  = (k >= 3) ? 10'((1020 + 3 * (k - 3)) % 1024) : 10'd500;
`else
         efwe = (k == 3) ? 2'b01 : 2'b00;
         ef0  = (k >= 3) ? 10'd1020 : 10'd500;
`endif
         got = {b2.vect_valid, b2.sample_num, b2.freq_offset_we,
                b2.freq_offset};
         exp = {1'b1, 10'(k), efwe, 10'd500, ef0};
         n_assert++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL sweep_k%0d: got %h want %h", k, got, exp);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      drive_init;
      rst = 1;
      test_reset;
      test_basic;
      test_stall;
      test_values;
      test_rst_mid;
      test_priority;
      test_run_len_one;
      test_sweep;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
